// File: rtl/writeback_stage.sv
// writeback_stage: registered write-back mux with bounded wait for late load data and a commit counter.
// Define WB_FWD_EN to drive the fwd_* bypass outputs from the registered write port; otherwise they are tied to 0.
module writeback_stage #(
    parameter int DataSize  = 32,
    parameter int AddrSize  = 5,
    parameter int DmTimeout = 15,
    parameter int CntSize   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                wb_en,
    input  logic [1:0]          wb_select,
    input  logic [AddrSize-1:0] wb_addr,
    input  logic [DataSize-1:0] alu_result,
    input  logic [DataSize-1:0] DMout,
    input  logic [DataSize-1:0] regData,
    input  logic [DataSize-1:0] pc_plus4,
    input  logic                dm_valid,
    output logic                rf_we,
    output logic [AddrSize-1:0] rf_waddr,
    output logic [DataSize-1:0] rf_wdata,
    output logic                dm_timeout,
    output logic [CntSize-1:0]  wb_count,
    output logic                fwd_valid,
    output logic [AddrSize-1:0] fwd_addr,
    output logic [DataSize-1:0] fwd_data
);
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] WAIT_DM = 1'b1;
    localparam int CW = $clog2(DmTimeout + 1);

    logic [0:0]          state;
    logic [CW-1:0]       wait_cnt;
    logic [DataSize-1:0] sel_data;
    logic                accept, go_wait, dm_done, dm_to, do_write;

    assign in_ready = (state == IDLE);

    // Source mux and the per-edge decisions: accept, start waiting, load arrival, give up.
    always_comb begin
        sel_data = wb_select == 2'b00 ? alu_result :
                   wb_select == 2'b01 ? DMout :
                   wb_select == 2'b10 ? regData : pc_plus4;
        accept   = in_valid && in_ready;
        go_wait  = accept && wb_en && wb_select == 2'b01 && !dm_valid;
        dm_done  = state == WAIT_DM && dm_valid;
        dm_to    = state == WAIT_DM && !dm_valid && wait_cnt == CW'(DmTimeout - 1);
        do_write = (accept && wb_en && !go_wait) || dm_done;
    end

    // Write port, FSM and counters; rf_waddr doubles as the pending-load address while waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            dm_timeout <= 1'b0;
            wb_count   <= '0;
        end else begin
            rf_we      <= do_write;
            dm_timeout <= dm_to;
            wb_count   <= wb_count + CntSize'(do_write);
            if (do_write) rf_wdata <= dm_done ? DMout : sel_data;
            if (accept && wb_en) rf_waddr <= wb_addr;
            if (go_wait) state <= WAIT_DM;
            else if (dm_done || dm_to) state <= IDLE;
            if (go_wait) wait_cnt <= '0;
            else if (state == WAIT_DM && !dm_valid) wait_cnt <= wait_cnt + CW'(1);
        end
    end

`ifdef WB_FWD_EN
    assign fwd_valid = rf_we;
    assign fwd_addr  = rf_waddr;
    assign fwd_data  = rf_wdata;
`else
    assign fwd_valid = 1'b0;
    assign fwd_addr  = '0;
    assign fwd_data  = '0;
`endif
endmodule

// File: doc/writeback_stage.md
# writeback_stage

Registered, parametrised write-back stage that selects among four result sources and writes the chosen value into the register file. It sits between the MEM stage and the register-file write port. Load data may arrive late from data memory: the stage waits for it under a ready/valid handshake, and gives up after a bounded wait. It also counts committed register writes.

## Interface
Parameters:
- DataSize, 32, width of every data path
- AddrSize, 5, register-file address width
- DmTimeout, 15, maximum number of cycles to wait for load data (minimum 1)
- CntSize, 16, width of wb_count

Ports (name, direction, width, meaning):
- clk  in  1  sole clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream presents a write-back request
- in_ready  out  1  stage can accept a request this cycle
- wb_en  in  1  request actually writes the register file
- wb_select  in  2  source select: 00 alu_result, 01 DMout, 10 regData, 11 pc_plus4
- wb_addr  in  AddrSize  destination register
- alu_result, DMout, regData, pc_plus4  in  DataSize each  candidate sources
- dm_valid  in  1  DMout holds valid load data this cycle
- rf_we  out  1  register-file write strobe (one-cycle pulse per write)
- rf_waddr  out  AddrSize  write address
- rf_wdata  out  DataSize  write data
- dm_timeout  out  1  one-cycle pulse when a load wait is abandoned
- wb_count  out  CntSize  number of committed writes, wrapping
- fwd_valid  out  1  forwarding valid (see Configuration)
- fwd_addr  out  AddrSize  forwarding address (see Configuration)
- fwd_data  out  DataSize  forwarding data (see Configuration)

## Operation
- A request is accepted when in_valid and in_ready are both 1 at a clock edge.
- The FSM has two states, IDLE and WAIT_DM. in_ready = (state == IDLE).
- Accepted request with wb_en = 0: no write and no wait; it is consumed.
- Accepted request with wb_en = 1 and select 00, 10 or 11: the stage registers the selected source into rf_wdata and wb_addr into rf_waddr, and pulses rf_we.
- Accepted request with wb_en = 1, select 01 and dm_valid = 1 on the same edge: DMout is written immediately (no wait).
- Accepted request with wb_en = 1, select 01 and dm_valid = 0: the stage latches wb_addr, enters WAIT_DM and clears the wait counter to 0.
- In WAIT_DM:
  - Each edge without dm_valid increments the wait counter.
  - On the first edge with dm_valid = 1, DMout is written to the latched address and the FSM returns to IDLE.
  - If the counter reaches DmTimeout with dm_valid still 0 at that edge: no write, dm_timeout pulses, FSM returns to IDLE.
  - dm_valid on the deciding edge wins over timeout.
- dm_valid is ignored while IDLE unless it accompanies an accepted DM request.
- in_valid is ignored while in WAIT_DM; upstream must hold its request.
- wb_count increments on every rf_we pulse and wraps from all-ones to 0.
- Reset values: state IDLE, rf_we 0, rf_waddr 0, rf_wdata 0, dm_timeout 0, wb_count 0, wait counter 0, fwd_* 0.
- Reset is dominant. Asserting rst while in WAIT_DM drops the pending load with no write and no dm_timeout pulse.

## Timing
- Latency: a request accepted at edge N produces rf_we = 1 for the cycle following N.
- Back-to-back non-DM requests are accepted every cycle, giving rf_we high continuously with a new address and data each cycle.
- Load completion: dm_valid sampled at edge M produces rf_we for the cycle after M; in_ready is 1 in that same cycle.
- Timeout: entering WAIT_DM at E0, the wait counter samples E1..E(DmTimeout). dm_timeout is high for the cycle after E(DmTimeout), and in_ready is 1 in that cycle.
- rf_we and dm_timeout are never both 1.
- in_ready is derived combinationally from state only.

## Configuration
- WB_FWD_EN defined:
  - fwd_valid = rf_we, fwd_addr = rf_waddr, fwd_data = rf_wdata (registered values), for EX-stage bypass.
  - While in WAIT_DM, fwd_addr shows the latched address and fwd_valid = 0, so the consumer can detect a load hazard by address.
- WB_FWD_EN not defined: fwd_valid, fwd_addr and fwd_data are tied to constant 0 and no forwarding logic is instantiated.

## Test plan
- Reset, then select 00 with alu_result=0x12345678, wb_addr=3, wb_en=1 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0x12345678, wb_count=1.
- Four back-to-back requests with selects 00/01/10/11 (dm_valid=1 on the 01 request), distinct data -> rf_we high four consecutive cycles with matching data; wb_count=4.
- Select 01, wb_addr=7, dm_valid low for 3 edges then DMout=0xCAFEF00D with dm_valid=1 -> in_ready low for 3 cycles; next cycle rf_we=1, rf_waddr=7, rf_wdata=0xCAFEF00D.
- DmTimeout=4, select 01, dm_valid never asserted -> dm_timeout pulses exactly once, 5 cycles after acceptance; no rf_we; wb_count unchanged; in_ready returns to 1.
- wb_en=0 with select 01 and dm_valid=0 -> no WAIT_DM entry, in_ready stays 1, no rf_we.
- rst asserted 2 cycles into WAIT_DM, then dm_valid=1 after reset -> no rf_we, no dm_timeout, all outputs 0. With WB_FWD_EN also check fwd_* mirror rf_* on every cycle of the previous scenarios.
